// File: rtl/feistel_key_schedule_pkg.sv
// Shared definitions for the Feistel key schedule.
// Contents: block/half widths of the round datapath, default key-schedule
// parameters, the FSM state encoding and the index-width helper.
package feistel_pkg;

    localparam int BLOCK_W    = 33;
    localparam int HALF_HI_W  = 17;
    localparam int HALF_LO_W  = 16;

    localparam int KEY_W_DEF      = 32;
    localparam int RKEY_W_DEF     = 17;
    localparam int NUM_ROUNDS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } ks_state_t;

    // Width of a round index; at least one bit even for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/feistel_key_schedule_if.sv
// Round-key stream from the key schedule to the round datapath.
// master (key schedule): drives Round_key, round_key_valid, Round_index,
//                        last_round; receives round_key_ack.
// slave  (datapath):     the reverse.
interface feistel_key_schedule_if #(
    parameter int RKEY_W = 17,
    parameter int IDX_W  = 3
);
    logic [RKEY_W-1:0] Round_key;
    logic              round_key_valid;
    logic [IDX_W-1:0]  Round_index;
    logic              last_round;
    logic              round_key_ack;

    modport master (
        output Round_key, round_key_valid, Round_index, last_round,
        input  round_key_ack
    );

    modport slave (
        input  Round_key, round_key_valid, Round_index, last_round,
        output round_key_ack
    );
endinterface

// File: rtl/feistel_rkey_regfile.sv
// Round-key table: NUM_ROUNDS x RKEY_W registers.
// Ports: clk/rst (async clear to 0), wr_en/wr_addr/wr_data synchronous
// write port, rd_addr -> rd_data combinational read port.
module feistel_rkey_regfile
    import feistel_pkg::*;
#(
    parameter int RKEY_W     = RKEY_W_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int IDX_W      = idx_width(NUM_ROUNDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [RKEY_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [RKEY_W-1:0] rd_data
);

    logic [RKEY_W-1:0] mem [NUM_ROUNDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feistel_key_schedule.sv
// Feistel round-key generator.
// Expands a master key into NUM_ROUNDS round keys (one per cycle), stores
// them, and streams them to the round datapath over rk_if, ascending for
// encryption and descending for decryption.
// Ports: clk, rst (async, active high); Key_in/key_load start an expansion;
// start/encrypt_en begin a stream; rk_if carries key/valid/index/last/ack;
// key_busy = expansion running, key_ready = table complete and idle.
//
// state  | meaning
// IDLE   | no key loaded since reset
// EXPAND | writing one table entry per cycle, rotating K
// READY  | table complete, waiting for start
// STREAM | presenting table[idx] until acked
module feistel_key_schedule
    import feistel_pkg::*;
#(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int RKEY_W     = RKEY_W_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int ROT        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_W-1:0]       Key_in,
    input  logic                   key_load,
    input  logic                   start,
    input  logic                   encrypt_en,
    feistel_key_schedule_if.master rk_if,
    output logic                   key_busy,
    output logic                   key_ready
);

    localparam int               IDX_W    = idx_width(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ROUNDS - 1);

    ks_state_t         state_q, state_d;
    logic [KEY_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              dir_q, dir_d;

    logic              wr_en;
    logic [RKEY_W-1:0] wr_data;
    logic [RKEY_W-1:0] rd_data;
    logic              streaming;
    logic              at_last;

    feistel_rkey_regfile #(
        .RKEY_W     (RKEY_W),
        .NUM_ROUNDS (NUM_ROUNDS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign wr_data   = k_q[RKEY_W-1:0] ^ RKEY_W'(cnt_q);
    assign streaming = (state_q == STREAM);
    // Terminal index depends on direction: top of table ascending, 0 descending.
    assign at_last   = dir_q ? (idx_q == IDX_LAST) : (idx_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        wr_en   = 1'b0;

        // A new key aborts whatever is in progress, including an expansion
        // (the aborted cycle does not write the table) and a stream.
        if (key_load) begin
            k_d     = Key_in;
            cnt_d   = '0;
            state_d = EXPAND;
        end else begin
            case (state_q)
                EXPAND: begin
                    wr_en = 1'b1;
                    k_d   = (k_q << ROT) | (k_q >> (KEY_W - ROT));
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_LAST) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (start) begin
                        dir_d   = encrypt_en;
                        idx_d   = encrypt_en ? '0 : IDX_LAST;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (rk_if.round_key_ack) begin
                        if (at_last) begin
                            state_d = READY;
                        end else if (dir_q) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_busy              = (state_q == EXPAND);
    assign key_ready             = (state_q == READY);
    assign rk_if.round_key_valid = streaming;
    assign rk_if.Round_key       = streaming ? rd_data : '0;
    assign rk_if.Round_index     = streaming ? idx_q : '0;
    assign rk_if.last_round      = streaming & at_last;

endmodule

// File: tb/tb_feistel_key_schedule.sv
module tb_feistel_key_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Key_in = '0;
    logic        key_load = 1'b0;
    logic        start = 1'b0;
    logic        encrypt_en = 1'b0;
    logic        key_busy;
    logic        key_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [16:0] rk;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];

    feistel_key_schedule_if #(.RKEY_W(17), .IDX_W(3)) rk_if ();

    feistel_key_schedule #(
        .KEY_W      (32),
        .RKEY_W     (17),
        .NUM_ROUNDS (8),
        .ROT        (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Key_in     (Key_in),
        .key_load   (key_load),
        .start      (start),
        .encrypt_en (encrypt_en),
        .rk_if      (rk_if),
        .key_busy   (key_busy),
        .key_ready  (key_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference expansion: rotate-left by 3 per step, low 17 bits xor index.
    function automatic logic [16:0] model_rk(input logic [31:0] key, input int i);
        logic [31:0] k;
        k = key;
        for (int r = 0; r < i; r++) k = {k[28:0], k[31:29]};
        return k[16:0] ^ 17'(i);
    endfunction

    task automatic push_stream(input logic [31:0] key, input logic enc, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            int i;
            i      = enc ? j : 7 - j;
            e.rk   = model_rk(key, i);
            e.idx  = 3'(i);
            e.last = (j == 7);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int stall);
        int   guard;
        exp_t e;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            guard++;
            if (rk_if.round_key_valid) begin
                e = sb[0];
                chk("round_key", 32'(rk_if.Round_key), 32'(e.rk));
                chk("round_index", 32'(rk_if.Round_index), 32'(e.idx));
                chk("last_round", 32'(rk_if.last_round), 32'(e.last));
                chk("key_ready_in_stream", 32'(key_ready), 32'd0);
                if (stall > 0) begin
                    stall--;
                    rk_if.round_key_ack = 1'b0;
                end else begin
                    rk_if.round_key_ack = 1'b1;
                    void'(sb.pop_front());
                end
            end else begin
                rk_if.round_key_ack = 1'b0;
            end
            step();
        end
        rk_if.round_key_ack = 1'b0;
        chk("drain_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!key_ready && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic load_key(input logic [31:0] key);
        Key_in   = key;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic start_stream(input logic enc);
        start      = 1'b1;
        encrypt_en = enc;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        rk_if.round_key_ack = 1'b0;

        // Reset state
        step();
        chk("rst_valid", 32'(rk_if.round_key_valid), 32'd0);
        chk("rst_key", 32'(rk_if.Round_key), 32'd0);
        chk("rst_busy", 32'(key_busy), 32'd0);
        chk("rst_ready", 32'(key_ready), 32'd0);
        rst = 1'b0;
        step();

        // 1: key 1, ascending, ack every cycle
        start = 1'b1;              // start in IDLE is ignored
        step();
        start = 1'b0;
        chk("idle_start_ignored", 32'(rk_if.round_key_valid), 32'd0);
        load_key(32'h0000_0001);
        chk("expand_busy", 32'(key_busy), 32'd1);
        wait_ready(n);
        chk("ready_latency", 32'(n), 32'd8);
        chk("busy_after_expand", 32'(key_busy), 32'd0);
        chk("model_rk3", 32'(model_rk(32'h1, 3)), 32'h00203);
        push_stream(32'h0000_0001, 1'b1, 8);
        start_stream(1'b1);
        drain(0);
        chk("ready_after_enc", 32'(key_ready), 32'd1);
        chk("valid_after_enc", 32'(rk_if.round_key_valid), 32'd0);

        // 2: same key, descending, no re-expansion
        push_stream(32'h0000_0001, 1'b0, 8);
        start_stream(1'b0);
        drain(0);
        chk("ready_after_dec", 32'(key_ready), 32'd1);

        // 3: key 0x80000001, ack stalled 5 cycles on key 0
        load_key(32'h8000_0001);
        wait_ready(n);
        chk("ready_latency3", 32'(n), 32'd8);
        push_stream(32'h8000_0001, 1'b1, 8);
        start_stream(1'b1);
        drain(5);

        // 4: key_load during STREAM at idx 3
        load_key(32'h0000_0001);
        wait_ready(n);
        push_stream(32'h0000_0001, 1'b1, 3);
        start_stream(1'b1);
        drain(0);
        chk("mid_stream_idx", 32'(rk_if.Round_index), 32'd3);
        chk("mid_stream_valid", 32'(rk_if.round_key_valid), 32'd1);
        load_key(32'h8000_0000);
        chk("abort_valid", 32'(rk_if.round_key_valid), 32'd0);
        chk("abort_busy", 32'(key_busy), 32'd1);
        wait_ready(n);
        chk("abort_ready_latency", 32'(n), 32'd8);
        push_stream(32'h8000_0000, 1'b1, 8);
        start_stream(1'b1);
        drain(0);

        // 5: start during EXPAND, then start+key_load in READY
        load_key(32'h0000_0001);
        start_stream(1'b1);
        chk("expand_start_valid", 32'(rk_if.round_key_valid), 32'd0);
        chk("expand_start_busy", 32'(key_busy), 32'd1);
        wait_ready(n);
        chk("expand_start_latency", 32'(n), 32'd7);
        rk_if.round_key_ack = 1'b1;  // ack outside STREAM is ignored
        step();
        step();
        rk_if.round_key_ack = 1'b0;
        chk("ack_in_ready", 32'(key_ready), 32'd1);
        Key_in   = 32'h8000_0001;
        key_load = 1'b1;
        start    = 1'b1;
        step();
        key_load = 1'b0;
        start    = 1'b0;
        chk("both_valid", 32'(rk_if.round_key_valid), 32'd0);
        chk("both_busy", 32'(key_busy), 32'd1);
        chk("both_ready", 32'(key_ready), 32'd0);
        wait_ready(n);
        chk("both_latency", 32'(n), 32'd8);
        push_stream(32'h8000_0001, 1'b0, 8);
        start_stream(1'b0);
        drain(0);

        // 6: async reset mid-EXPAND
        load_key(32'h0000_0001);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(key_busy), 32'd0);
        chk("arst_ready", 32'(key_ready), 32'd0);
        chk("arst_valid", 32'(rk_if.round_key_valid), 32'd0);
        chk("arst_key", 32'(rk_if.Round_key), 32'd0);
        chk("arst_last", 32'(rk_if.last_round), 32'd0);
        step();
        rst = 1'b0;
        start      = 1'b1;
        encrypt_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        start = 1'b0;
        chk("post_rst_busy", 32'(key_busy), 32'd0);
        chk("post_rst_ready", 32'(key_ready), 32'd0);
        chk("post_rst_valid", 32'(rk_if.round_key_valid), 32'd0);
        load_key(32'h0000_0001);
        wait_ready(n);
        chk("post_rst_latency", 32'(n), 32'd8);
        push_stream(32'h0000_0001, 1'b1, 8);
        start_stream(1'b1);
        drain(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feistel_key_schedule.md
Name: feistel_key_schedule

Overview:
- Round-key generator sitting directly upstream of the Feistel round datapath (33-bit block, 16/17-bit halves).
- Expands a loaded master key into NUM_ROUNDS round keys, one per cycle, and stores them.
- Streams the stored keys to the round datapath under a valid/ack handshake: ascending order for encryption, descending order for decryption.

Parameters:
- KEY_W, 32, master key width.
- RKEY_W, 17, round key width; matches the wider half of the 33-bit block.
- NUM_ROUNDS, 8, rounds per block; must be ≥2 and a power of 2.
- ROT, 3, left-rotate amount applied to the key register per expansion step; must be <KEY_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Key_in  in  KEY_W  master key; sampled when key_load=1.
- key_load  in  1  pulse; starts a new expansion.
- start  in  1  pulse; begins streaming keys for one block.
- encrypt_en  in  1  sampled with start; 1 selects ascending order, 0 selects descending order.
- round_key_ack  in  1  consumer has taken the current Round_key.
- Round_key  out  RKEY_W  current round key.
- round_key_valid  out  1  Round_key is valid.
- Round_index  out  log2(NUM_ROUNDS)  index of the current key.
- last_round  out  1  current key is the final key of the stream.
- key_busy  out  1  expansion is in progress.
- key_ready  out  1  key table is complete and no stream is active.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; key table cleared to 0; internal counters and key register cleared to 0.
- States: IDLE, EXPAND, READY, STREAM.
- IDLE:
  - key_load → capture Key_in into K, set cnt=0, go to EXPAND.
  - start is ignored.
- EXPAND (key_busy=1), each edge:
  - table[cnt] <= K[RKEY_W-1:0] ^ zero-extended cnt.
  - K <= rotl(K, ROT); cnt++.
  - After the edge that writes entry NUM_ROUNDS-1, go to READY.
  - key_ready rises exactly NUM_ROUNDS edges after the key_load edge.
- READY (key_ready=1):
  - start → capture encrypt_en into dir.
  - idx <= 0 if dir=1, idx <= NUM_ROUNDS-1 if dir=0.
  - Go to STREAM.
- STREAM (round_key_valid=1, key_ready=0):
  - Round_key = table[idx]; Round_index = idx; all combinational from registers.
  - last_round=1 when idx is the terminal index (NUM_ROUNDS-1 ascending, 0 descending).
  - On ack: step idx by +1 (ascending) or -1 (descending). Ack on the last key returns to READY on that edge.
  - Without ack, all outputs hold.
  - A key stays valid until acked; back-to-back acks give one key per cycle.
- Key table persists across blocks; repeated start pulses need no re-expansion.
- Boundaries:
  - key_load in any non-reset state aborts the current activity (including mid-EXPAND and mid-STREAM) and restarts EXPAND with the new Key_in. round_key_valid drops on the following edge.
  - key_load and start in the same cycle: key_load wins.
  - start outside READY: ignored.
  - round_key_ack outside STREAM: ignored.
  - idx never wraps. The terminal ack exits STREAM instead of stepping idx.
  - rst asserted mid-operation clears everything immediately. A new key_load is required afterwards.

Decomposition:
- Shared package/include feistel_pkg:
  - BLOCK_W=33, HALF_HI_W=17, HALF_LO_W=16.
  - Default KEY_W, RKEY_W and NUM_ROUNDS.
  - State encoding constants (IDLE=2'd0, EXPAND=2'd1, READY=2'd2, STREAM=2'd3).
  - Index width function.
- One sub-module, feistel_rkey_regfile:
  - NUM_ROUNDS×RKEY_W register array.
  - One synchronous write port, one combinational read port, asynchronous clear.

Test Plan:
1. Key_in=0x00000001, key_load, then start with encrypt_en=1, ack every cycle → Round_key sequence 0x00001, 0x00009, 0x00042, 0x00203, …, final 0x00007. last_round=1 only on the final key. key_ready returns 1 after the last ack.
2. Same key, start with encrypt_en=0 → first key 0x00007 with Round_index=7, last key 0x00001 with Round_index=0.
3. Key_in=0x80000001 with ack held low 5 cycles on key 0 → Round_key/Round_index hold steady; key 1 = 0x0000D only after the ack.
4. key_load of 0x80000000 during STREAM at idx=3 → round_key_valid=0 next cycle. key_ready=1 exactly 8 edges after the load edge. New table rk0=0x00000, rk1=0x00005.
5. start during EXPAND, then start and key_load in the same READY cycle → no stream starts; expansion restarts; key_busy=1.
6. rst pulsed mid-EXPAND (asynchronous, between clock edges) → all outputs 0 immediately; no state advance until a new key_load.
